// File: rtl/fp_sub_seq.sv
// Sequential half-precision subtractor (result = a - b). Alignment and normalisation
// move one bit per cycle, so latency depends on exponent distance and cancellation.
module fp_sub_seq #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 overflow
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int MW = MAN_W + 2;
   localparam int CW = $clog2(MW + 1);
   localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADDSUB, NORM, DONE} state_t;

   state_t         state, state_n;
   logic           sign_r, sign_n, sub_r, sub_n;
   logic [EXP_W:0] exp_r, exp_n, exp_inc, exp_dec;
   logic [MW-1:0]  mx_r, mx_n, my_r, my_n, m_sum;
   logic [CW-1:0]  cnt_r, cnt_n;
   logic [W-1:0]   res_n;
   logic           ovf_n;

   logic             a_big, sx, sy;
   logic [W-2:0]     mag_x, mag_y;
   logic [EXP_W-1:0] ex, ey;
   logic [MW-1:0]    mx_ld, my_ld;
   logic [31:0]      diff;

   // Operand decode for the IDLE load: b's sign is inverted so the datapath adds.
   assign a_big = (a[W-2:0] >= b[W-2:0]);
   assign mag_x = a_big ? a[W-2:0] : b[W-2:0];
   assign mag_y = a_big ? b[W-2:0] : a[W-2:0];
   assign sx    = a_big ? a[W-1] : ~b[W-1];
   assign sy    = a_big ? ~b[W-1] : a[W-1];
   assign ex    = mag_x[W-2:MAN_W];
   assign ey    = mag_y[W-2:MAN_W];
   assign mx_ld = (ex == '0) ? '0 : {2'b01, mag_x[MAN_W-1:0]};
   assign my_ld = (ey == '0) ? '0 : {2'b01, mag_y[MAN_W-1:0]};
   assign diff  = 32'(ex) - 32'(ey);

   assign exp_inc = exp_r + (EXP_W+1)'(1);
   assign exp_dec = exp_r - (EXP_W+1)'(1);
   assign m_sum   = sub_r ? (mx_r - my_r) : (mx_r + my_r);

   // Handshake: start is sampled only in IDLE; busy is high in every other state;
   // done pulses for the single DONE cycle, and result/overflow hold until the next done.
   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_comb begin
      state_n = state;
      sign_n  = sign_r;
      sub_n   = sub_r;
      exp_n   = exp_r;
      mx_n    = mx_r;
      my_n    = my_r;
      cnt_n   = cnt_r;
      res_n   = result;
      ovf_n   = overflow;
      case (state)
         IDLE: begin
            if (start) begin
               state_n = ALIGN;
               sign_n  = sx;
               sub_n   = (sx != sy);
               exp_n   = {1'b0, ex};
               mx_n    = mx_ld;
               my_n    = my_ld;
               cnt_n   = (diff > 32'(MW)) ? CW'(MW) : CW'(diff);
            end
         end
         ALIGN: begin
            if (cnt_r != '0) begin
               my_n  = my_r >> 1;
               cnt_n = cnt_r - CW'(1);
            end else begin
               state_n = ADDSUB;
            end
         end
         ADDSUB: begin
            mx_n    = m_sum;
            state_n = NORM;
         end
         NORM: begin
            if (mx_r[MW-1]) begin
               state_n = DONE;
               mx_n    = mx_r >> 1;
               exp_n   = exp_inc;
               if (exp_inc >= EXP_MAX) begin
                  res_n = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                  ovf_n = 1'b1;
               end else begin
                  res_n = {sign_r, exp_inc[EXP_W-1:0], mx_r[MAN_W:1]};
                  ovf_n = 1'b0;
               end
            end else if (mx_r == '0) begin
               state_n = DONE;
               res_n   = '0;
               ovf_n   = 1'b0;
            end else if (mx_r[MW-2]) begin
               state_n = DONE;
               res_n   = {sign_r, exp_r[EXP_W-1:0], mx_r[MAN_W-1:0]};
               ovf_n   = 1'b0;
            end else begin
               mx_n  = mx_r << 1;
               exp_n = exp_dec;
               // Exponent exhausted before the hidden bit surfaced: flush to +0.
               if (exp_dec == '0) begin
                  state_n = DONE;
                  res_n   = '0;
                  ovf_n   = 1'b0;
               end
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sign_r   <= 1'b0;
         sub_r    <= 1'b0;
         exp_r    <= '0;
         mx_r     <= '0;
         my_r     <= '0;
         cnt_r    <= '0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= state_n;
         sign_r   <= sign_n;
         sub_r    <= sub_n;
         exp_r    <= exp_n;
         mx_r     <= mx_n;
         my_r     <= my_n;
         cnt_r    <= cnt_n;
         result   <= res_n;
         overflow <= ovf_n;
      end
   end
endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: directed cases pinned to literals, then randomized operands
// checked against an arithmetic model through an expected-result scoreboard.
module tb_fp_sub_seq;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, overflow;
   logic [W-1:0] result;

   fp_sub_seq #(.EXP_W(5), .MAN_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .overflow(overflow)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   logic         ovf_q[$];
   int           cyc_q[$];
   logic [W-1:0] held_res = '0;
   logic         held_ovf = 1'b0;
   int           busy_from = 1;
   int           busy_to = 0;
   int           done_cnt = 0;
   int           n_vec = 0;
   int           n_err = 0;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
      end
   endfunction

   // Reference: a - b as a + (-b), aligned by one truncating shift, then normalised.
   function automatic void model(input logic [15:0] ta, input logic [15:0] tb_,
                                 output logic [15:0] r, output logic o, output int lat);
      logic [15:0] x, y;
      logic        sx, sy;
      int          ex, ey, mx, my, d, m, e, k;
      x = ta; y = tb_; sx = ta[15]; sy = ~tb_[15];
      if (tb_[14:0] > ta[14:0]) begin
         x = tb_; y = ta; sx = ~tb_[15]; sy = ta[15];
      end
      ex = int'(x[14:10]);
      ey = int'(y[14:10]);
      mx = (ex == 0) ? 0 : 1024 + int'(x[9:0]);
      my = (ey == 0) ? 0 : 1024 + int'(y[9:0]);
      d  = ex - ey;
      if (d > 12) d = 12;
      my = my / (1 << d);
      m  = (sx == sy) ? mx + my : mx - my;
      r = 16'h0000; o = 1'b0; k = 0;
      lat = d + 4;
      if (m >= 2048) begin
         e = ex + 1;
         if (e >= 31) begin
            r = {sx, 5'h1f, 10'h000};
            o = 1'b1;
         end else begin
            r = {sx, 5'(e), 10'(m / 2)};
         end
      end else if (m != 0) begin
         while ((m << k) < 1024) k++;
         if (k >= ex) begin
            // flush happens on the shift that empties the exponent; no final NORM visit
            lat = d + ex + 3;
         end else begin
            r   = {sx, 5'(ex - k), 10'(m << k)};
            lat = d + k + 4;
         end
      end
   endfunction

   // ---------------- compare process ----------------
   logic [W-1:0] pop_r;
   logic         pop_o;
   int           pop_c;

   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc <= busy_to));
         if (done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               pop_r = exp_q.pop_front();
               pop_o = ovf_q.pop_front();
               pop_c = cyc_q.pop_front();
               chk("result", 32'(result), 32'(pop_r));
               chk("overflow", 32'(overflow), 32'(pop_o));
               chk("done_cycle", 32'(cyc), 32'(pop_c));
               held_res = pop_r;
               held_ovf = pop_o;
            end
            done_cnt++;
         end else begin
            chk("result_hold", 32'(result), 32'(held_res));
            chk("overflow_hold", 32'(overflow), 32'(held_ovf));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_model();
      exp_q.delete();
      ovf_q.delete();
      cyc_q.delete();
      busy_from = 1;
      busy_to   = 0;
      held_res  = '0;
      held_ovf  = 1'b0;
   endtask

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input bit hold,
                         input bit lit, input logic [15:0] lr, input bit lo, input int ll);
      logic [15:0] mr;
      logic        mo;
      int          ml, c0, seen, t;
      model(ta, tb_, mr, mo, ml);
      if (lit) begin
         chk("model_result", 32'(mr), 32'(lr));
         chk("model_overflow", 32'(mo), 32'(lo));
         chk("model_latency", 32'(ml), 32'(ll));
      end
      @(negedge clk);
      a = ta; b = tb_; start = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      exp_q.push_back(mr);
      ovf_q.push_back(mo);
      cyc_q.push_back(c0 + ml - 1);
      busy_from = c0;
      busy_to   = c0 + ml - 1;
      if (!hold) start = 1'b0;
      seen = done_cnt;
      t = 0;
      while (done_cnt == seen && t < 40) begin
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      if (done_cnt == seen) begin
         chk("done_timeout", 32'(done_cnt), 32'(seen + 1));
         rst_n = 1'b0;
         clear_model();
         @(posedge clk);
         #2 rst_n = 1'b1;
      end
   endtask

   // ---------------- stimulus ----------------
   logic [15:0] d_a[7] = '{16'h3E00, 16'h3C00, 16'h4000, 16'h3C00, 16'h4248, 16'h0401, 16'h3C00};
   logic [15:0] d_b[7] = '{16'h3C00, 16'h4000, 16'h3C00, 16'hBC00, 16'h4248, 16'h0400, 16'h0400};
   logic [15:0] d_r[7] = '{16'h3800, 16'hBC00, 16'h3C00, 16'h4000, 16'h0000, 16'h0000, 16'h3C00};
   int          d_l[7] = '{5, 6, 6, 4, 4, 4, 16};

   initial begin
      logic [15:0] ta, tb_;
      int          ea, eb, mode;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_result", 32'(result), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_op(d_a[i], d_b[i], 1'b0, 1'b1, d_r[i], 1'b0, d_l[i]);
      run_op(16'h7BFF, 16'hFBFF, 1'b0, 1'b1, 16'h7C00, 1'b1, 4);

      // Reset in the middle of a long alignment: outputs clear at once, no done follows.
      @(negedge clk);
      a = 16'h3C00; b = 16'h0400; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_from = cyc;
      busy_to   = cyc + 100;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      clear_model();
      #1;
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_done", 32'(done), 32'd0);
      chk("midreset_result", 32'(result), 32'd0);
      chk("midreset_overflow", 32'(overflow), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (30) @(negedge clk);

      // start held high across the whole operation yields a single done.
      run_op(16'h3E00, 16'h3C00, 1'b1, 1'b1, 16'h3800, 1'b0, 5);
      repeat (10) @(negedge clk);

      for (int i = 0; i < 160; i++) begin
         ea   = $urandom_range(0, 30);
         eb   = $urandom_range(0, 30);
         mode = $urandom_range(0, 3);
         ta   = {1'($urandom_range(0, 1)), 5'(ea), 10'($urandom)};
         tb_  = {1'($urandom_range(0, 1)), 5'(eb), 10'($urandom)};
         if (mode == 1) tb_[14:10] = ta[14:10];
         if (mode == 2) tb_ = {ta[15], ta[14:3], 3'($urandom)};
         if (mode == 3) tb_ = {~ta[15], ta[14:10], 10'($urandom)};
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(ta, tb_, 1'($urandom_range(0, 1)), 1'b0, 16'h0000, 1'b0, 0);
      end

      repeat (5) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
